// File: rtl/block_move_ctrl.sv
// Bouncing-block motion controller: advances a square block once every FRAME_DIV
// frames and reflects it off the inner edge of the display border.
module block_move_ctrl #(
    parameter logic [10:0] H_DISP    = 11'd1280,
    parameter logic [10:0] V_DISP    = 11'd720,
    parameter logic [10:0] SIDE_W    = 11'd40,
    parameter logic [10:0] BLOCK_W   = 11'd40,
    parameter logic [7:0]  FRAME_DIV = 8'd1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    input  logic        pause,
    input  logic [3:0]  speed_x,
    input  logic [3:0]  speed_y,
    output logic [10:0] block_x,
    output logic [10:0] block_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic        pos_upd,
    output logic        corner_hit,
    output logic [1:0]  fsm_state
);

    localparam logic [11:0] X_MIN = {1'b0, SIDE_W};
    localparam logic [11:0] Y_MIN = {1'b0, SIDE_W};
    localparam logic [11:0] X_MAX = {1'b0, H_DISP} - {1'b0, SIDE_W} - {1'b0, BLOCK_W};
    localparam logic [11:0] Y_MAX = {1'b0, V_DISP} - {1'b0, SIDE_W} - {1'b0, BLOCK_W};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_CALC   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  frm_cnt, frm_cnt_nxt;

    logic [10:0] x_next, y_next;
    logic        x_dir_next, y_dir_next, x_bounce, y_bounce;
    logic [10:0] calc_x, calc_y;
    logic        calc_dx, calc_dy, calc_bx, calc_by;

    assign fsm_state = state;

    always_comb begin
        state_nxt   = state;
        frm_cnt_nxt = frm_cnt;
        case (state)
            S_IDLE: if (frame_start) state_nxt = S_WAIT;
            S_WAIT: begin
                if (frame_start && !pause) begin
                    if (frm_cnt == FRAME_DIV - 8'd1) begin
                        frm_cnt_nxt = 8'd0;
                        state_nxt   = S_CALC;
                    end else begin
                        frm_cnt_nxt = frm_cnt + 8'd1;
                    end
                end
            end
            S_CALC:   state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_WAIT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Compares are done 12 bits wide so pos+speed near the right edge cannot wrap.
    always_comb begin
        x_next     = block_x;
        x_dir_next = dir_x;
        x_bounce   = 1'b0;
        if (speed_x != 4'd0) begin
            if (dir_x) begin
                if ({1'b0, block_x} + {8'd0, speed_x} >= X_MAX) begin
                    x_next     = X_MAX[10:0];
                    x_dir_next = 1'b0;
                    x_bounce   = 1'b1;
                end else begin
                    x_next = block_x + {7'd0, speed_x};
                end
            end else begin
                if ({1'b0, block_x} <= X_MIN + {8'd0, speed_x}) begin
                    x_next     = X_MIN[10:0];
                    x_dir_next = 1'b1;
                    x_bounce   = 1'b1;
                end else begin
                    x_next = block_x - {7'd0, speed_x};
                end
            end
        end
    end

    always_comb begin
        y_next     = block_y;
        y_dir_next = dir_y;
        y_bounce   = 1'b0;
        if (speed_y != 4'd0) begin
            if (dir_y) begin
                if ({1'b0, block_y} + {8'd0, speed_y} >= Y_MAX) begin
                    y_next     = Y_MAX[10:0];
                    y_dir_next = 1'b0;
                    y_bounce   = 1'b1;
                end else begin
                    y_next = block_y + {7'd0, speed_y};
                end
            end else begin
                if ({1'b0, block_y} <= Y_MIN + {8'd0, speed_y}) begin
                    y_next     = Y_MIN[10:0];
                    y_dir_next = 1'b1;
                    y_bounce   = 1'b1;
                end else begin
                    y_next = block_y - {7'd0, speed_y};
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            frm_cnt    <= 8'd0;
            calc_x     <= X_MIN[10:0];
            calc_y     <= Y_MIN[10:0];
            calc_dx    <= 1'b1;
            calc_dy    <= 1'b1;
            calc_bx    <= 1'b0;
            calc_by    <= 1'b0;
            block_x    <= X_MIN[10:0];
            block_y    <= Y_MIN[10:0];
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            pos_upd    <= 1'b0;
            corner_hit <= 1'b0;
        end else begin
            state      <= state_nxt;
            frm_cnt    <= frm_cnt_nxt;
            pos_upd    <= (state == S_COMMIT);
            corner_hit <= (state == S_COMMIT) && calc_bx && calc_by;
            if (state == S_CALC) begin
                calc_x  <= x_next;
                calc_y  <= y_next;
                calc_dx <= x_dir_next;
                calc_dy <= y_dir_next;
                calc_bx <= x_bounce;
                calc_by <= y_bounce;
            end
            // Visible outputs only move on the edge leaving COMMIT.
            if (state == S_COMMIT) begin
                block_x <= calc_x;
                block_y <= calc_y;
                dir_x   <= calc_dx;
                dir_y   <= calc_dy;
            end
        end
    end

endmodule

// File: tb/tb_block_move_ctrl.sv
// Bench for block_move_ctrl: two instances (FRAME_DIV 1 and 3) share stimulus;
// expected commits are queued at issue time and popped by a monitor on pos_upd.
module tb_block_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, pause;
    logic [3:0]  speed_x, speed_y;

    logic [10:0] x1, y1, x3, y3;
    logic        dx1, dy1, upd1, ch1, dx3, dy3, upd3, ch3;
    logic [1:0]  st1, st3;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int upd_cnt1 = 0, upd_cnt3 = 0, corner_cnt1 = 0;
    int base;

    logic [24:0] exp_q1[$], exp_q3[$];
    int          cyc_q1[$], cyc_q3[$];
    logic [24:0] mon_e1, mon_e3;
    int          mon_c1, mon_c3;

    int          m_div[2] = '{1, 3};
    logic        m_armed[2];
    int          m_cnt[2], m_busy[2];
    logic [10:0] m_x[2], m_y[2];
    logic        m_dx[2], m_dy[2];

    block_move_ctrl #(.FRAME_DIV(8'd1)) u_div1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .frame_start(frame_start), .pause(pause),
        .speed_x(speed_x), .speed_y(speed_y), .block_x(x1), .block_y(y1),
        .dir_x(dx1), .dir_y(dy1), .pos_upd(upd1), .corner_hit(ch1), .fsm_state(st1)
    );

    block_move_ctrl #(.FRAME_DIV(8'd3)) u_div3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .frame_start(frame_start), .pause(pause),
        .speed_x(speed_x), .speed_y(speed_y), .block_x(x3), .block_y(y3),
        .dir_x(dx3), .dir_y(dy3), .pos_upd(upd3), .corner_hit(ch3), .fsm_state(st3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {bounce, new_dir, new_pos}.
    function automatic logic [12:0] axis_step(input logic [10:0] p, input logic d,
                                              input logic [3:0] s, input int mn, input int mx);
        int pi = int'(p);
        int si = int'(s);
        if (si == 0) return {1'b0, d, p};
        if (d) begin
            if (pi + si >= mx) return {1'b1, 1'b0, 11'(mx)};
            return {1'b0, 1'b1, 11'(pi + si)};
        end
        if (pi <= mn + si) return {1'b1, 1'b1, 11'(mn)};
        return {1'b0, 1'b0, 11'(pi - si)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 1'b0; m_cnt[i] = 0; m_busy[i] = -1;
            m_x[i] = 11'd40; m_y[i] = 11'd40; m_dx[i] = 1'b1; m_dy[i] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives one frame_start in the current cycle and advances both models.
    task automatic do_pulse(input logic p, input logic [3:0] sx, input logic [3:0] sy);
        logic [12:0] rx, ry;
        frame_start = 1'b1; pause = p; speed_x = sx; speed_y = sy;
        for (int i = 0; i < 2; i++) begin
            if (!m_armed[i]) begin
                m_armed[i] = 1'b1;
            end else if (cyc > m_busy[i] && !p) begin
                if (m_cnt[i] == m_div[i] - 1) begin
                    m_cnt[i]  = 0;
                    m_busy[i] = cyc + 2;
                    rx = axis_step(m_x[i], m_dx[i], sx, 40, 1200);
                    ry = axis_step(m_y[i], m_dy[i], sy, 40, 640);
                    m_x[i] = rx[10:0]; m_dx[i] = rx[11];
                    m_y[i] = ry[10:0]; m_dy[i] = ry[11];
                    if (i == 0) begin
                        exp_q1.push_back({m_x[i], m_y[i], m_dx[i], m_dy[i], rx[12] & ry[12]});
                        cyc_q1.push_back(cyc + 3);
                    end else begin
                        exp_q3.push_back({m_x[i], m_y[i], m_dx[i], m_dy[i], rx[12] & ry[12]});
                        cyc_q3.push_back(cyc + 3);
                    end
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic frame(input logic p, input logic [3:0] sx, input logic [3:0] sy);
        @(negedge clk); do_pulse(p, sx, sy);
        @(negedge clk); frame_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Trigger pulse followed by pulses landing in CALC and COMMIT.
    task automatic burst(input logic [3:0] sx, input logic [3:0] sy);
        @(negedge clk); do_pulse(1'b0, sx, sy);
        @(negedge clk); do_pulse(1'b0, sx, sy);
        @(negedge clk); do_pulse(1'b0, sx, sy);
        @(negedge clk); frame_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (upd1) begin
            upd_cnt1++;
            n_vec++;
            if (exp_q1.size() == 0) begin
                n_err++;
                $display("FAIL div1_upd: unexpected pos_upd at cycle %0d, expected none", cyc);
            end else begin
                mon_e1 = exp_q1.pop_front();
                mon_c1 = cyc_q1.pop_front();
                if ({x1, y1, dx1, dy1, ch1} !== mon_e1 || cyc != mon_c1) begin
                    n_err++;
                    $display("FAIL div1_upd: got x=%0d y=%0d dx=%0b dy=%0b ch=%0b cyc=%0d, expected x=%0d y=%0d dx=%0b dy=%0b ch=%0b cyc=%0d",
                             x1, y1, dx1, dy1, ch1, cyc, mon_e1[24:14], mon_e1[13:3],
                             mon_e1[2], mon_e1[1], mon_e1[0], mon_c1);
                end
            end
        end
        if (ch1) corner_cnt1++;
        if (upd3) begin
            upd_cnt3++;
            n_vec++;
            if (exp_q3.size() == 0) begin
                n_err++;
                $display("FAIL div3_upd: unexpected pos_upd at cycle %0d, expected none", cyc);
            end else begin
                mon_e3 = exp_q3.pop_front();
                mon_c3 = cyc_q3.pop_front();
                if ({x3, y3, dx3, dy3, ch3} !== mon_e3 || cyc != mon_c3) begin
                    n_err++;
                    $display("FAIL div3_upd: got x=%0d y=%0d dx=%0b dy=%0b ch=%0b cyc=%0d, expected x=%0d y=%0d dx=%0b dy=%0b ch=%0b cyc=%0d",
                             x3, y3, dx3, dy3, ch3, cyc, mon_e3[24:14], mon_e3[13:3],
                             mon_e3[2], mon_e3[1], mon_e3[0], mon_c3);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pause = 1'b0; speed_x = 4'd0; speed_y = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_x1", int'(x1), 40);   chk("rst_y1", int'(y1), 40);
        chk("rst_dx1", int'(dx1), 1);  chk("rst_dy1", int'(dy1), 1);
        chk("rst_upd1", int'(upd1), 0); chk("rst_ch1", int'(ch1), 0);
        chk("rst_st1", int'(st1), 0);
        chk("rst_x3", int'(x3), 40);   chk("rst_y3", int'(y3), 40);
        chk("rst_st3", int'(st3), 0);

        // Arming pulse, then 7 counted frames.
        frame(1'b0, 4'd4, 4'd2);
        chk("arm_no_upd", upd_cnt1, 0);
        frame(1'b0, 4'd4, 4'd2);
        chk("first_x", int'(x1), 44);
        chk("first_y", int'(y1), 42);
        for (int k = 0; k < 6; k++) frame(1'b0, 4'd4, 4'd2);
        chk("div3_count", upd_cnt3, 2);
        chk("div1_count", upd_cnt1, 7);

        for (int k = 0; k < 5; k++) frame(1'b1, 4'd4, 4'd2);
        chk("pause_x", int'(x1), 68);
        chk("pause_y", int'(y1), 54);
        chk("pause_upd1", upd_cnt1, 7);
        chk("pause_upd3", upd_cnt3, 2);
        frame(1'b0, 4'd4, 4'd2);
        chk("resume1_upd3", upd_cnt3, 2);
        frame(1'b0, 4'd4, 4'd2);
        chk("resume2_upd3", upd_cnt3, 3);
        chk("resume_x", int'(x1), 76);

        // Right-edge bounce from 1197 at speed 5.
        for (int k = 0; k < 74; k++) frame(1'b0, 4'd15, 4'd0);
        frame(1'b0, 4'd11, 4'd0);
        chk("near_edge_x", int'(x1), 1197);
        chk("near_edge_dx", int'(dx1), 1);
        frame(1'b0, 4'd5, 4'd0);
        chk("edge_x", int'(x1), 1200);
        chk("edge_dx", int'(dx1), 0);
        frame(1'b0, 4'd5, 4'd0);
        chk("after_edge_x", int'(x1), 1195);

        // Reset pulse while u_div1 is in CALC.
        base = upd_cnt1;
        @(negedge clk); frame_start = 1'b1; pause = 1'b0; speed_x = 4'd3; speed_y = 4'd3;
        @(negedge clk); frame_start = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        chk("abort_x", int'(x1), 40);  chk("abort_y", int'(y1), 40);
        chk("abort_dx", int'(dx1), 1); chk("abort_dy", int'(dy1), 1);
        chk("abort_st", int'(st1), 0);
        repeat (4) @(negedge clk);
        chk("abort_no_upd", upd_cnt1, base);
        frame(1'b0, 4'd15, 4'd15);
        chk("rearm_x", int'(x1), 40);
        frame(1'b0, 4'd15, 4'd15);
        chk("restart_x", int'(x1), 55);
        chk("restart_y", int'(y1), 55);

        // Both axes reach their far limits in the same step.
        for (int k = 0; k < 38; k++) frame(1'b0, 4'd15, 4'd15);
        for (int k = 0; k < 38; k++) frame(1'b0, 4'd15, 4'd0);
        chk("pre_corner_x", int'(x1), 1195);
        chk("pre_corner_y", int'(y1), 625);
        frame(1'b0, 4'd5, 4'd15);
        chk("corner_x", int'(x1), 1200);  chk("corner_y", int'(y1), 640);
        chk("corner_dx", int'(dx1), 0);   chk("corner_dy", int'(dy1), 0);
        chk("corner_pulses", corner_cnt1, 1);

        // Zero speed plus frame_start pulses landing in CALC/COMMIT.
        base = upd_cnt1;
        burst(4'd0, 4'd0);
        chk("burst_upd1", upd_cnt1, base + 1);
        chk("zero_speed_x", int'(x1), 1200);
        chk("zero_speed_y", int'(y1), 640);

        repeat (5) @(negedge clk);
        chk("q1_drained", exp_q1.size(), 0);
        chk("q3_drained", exp_q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
